// File: rtl/audio_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
// Shared constants and types for the audio output stage.
//   SAMPLE_W      default sample width in bits
//   I2S_SLOTS     bclk slots per stereo frame (left word + right word)
//   LEVEL_W       FIFO occupancy width for the default 8-entry FIFO
//   tx_state_t    serializer state (IDLE, RUN)
//   level_width() occupancy width for an arbitrary FIFO depth
// ----------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_W           = 16;
    localparam int I2S_SLOTS          = 2 * SAMPLE_W;
    localparam int FIFO_DEPTH_DEFAULT = 8;
    localparam int LEVEL_W            = $clog2(FIFO_DEPTH_DEFAULT) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

    // Occupancy needs one extra bit so that "completely full" is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// ----------------------------------------------------------------------------
// audio_sample_fifo
// Small synchronous sample FIFO with an occupancy counter.
//   clk          system clock, rising edge
//   i_rst_n      asynchronous active-low reset (empties the FIFO)
//   i_push       write request; ignored while full
//   i_push_data  write data
//   i_pop        read request; ignored while empty
//   o_head       entry at the read pointer (valid while not empty)
//   o_full       DEPTH entries held
//   o_empty      no entries held
//   o_level      current occupancy, 0..DEPTH
// DEPTH must be a power of two and at least 2, so the pointers wrap for free.
// ----------------------------------------------------------------------------
module audio_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_push;
    logic w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage is not reset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Head is read combinationally so the frame loader gets the sample in the
    // same cycle it pops; at this depth the array maps to distributed RAM.
    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/audio_i2s_tx.sv
// ----------------------------------------------------------------------------
// audio_i2s_tx
// Buffers processed mono samples and streams each one as a duplicated
// left/right I2S frame (MSB first, one-bit delay after lrclk changes).
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   tx_en         enables serialization (FIFO still accepts writes when low)
//   sample_in     sample from the pitch stage
//   sample_valid  sample_in valid this cycle
//   sample_ready  FIFO not full
//   underrun_clr  clears the sticky underrun flag
//   bclk          I2S bit clock, half-period = BCLK_DIV clk cycles
//   lrclk         I2S word select, 0 = left, 1 = right
//   sdata         I2S serial data
//   fifo_level    FIFO occupancy
//   underrun      sticky: a frame started with the FIFO empty
// Optional build macro AUDIO_I2S_TX_HOLD_LAST_EN: an underrun frame repeats
// the last popped sample instead of sending silence.
// ----------------------------------------------------------------------------
module audio_i2s_tx #(
    parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
    parameter int FIFO_DEPTH = 8,
    parameter int BCLK_DIV   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_en,
    input  logic [SAMPLE_W-1:0]           sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          underrun_clr,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
);

    import audio_pkg::*;

    localparam int N_SLOTS = 2 * SAMPLE_W;
    localparam int SLOT_W  = $clog2(N_SLOTS);
    localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int LVL_W   = level_width(FIFO_DEPTH);

    // ---------------- state registers ----------------
    tx_state_t           r_state;
    logic [DIV_W-1:0]    r_div;
    logic                r_bclk;
    logic                r_lrclk;
    logic                r_sdata;
    logic [SLOT_W-1:0]   r_slot;
    logic [N_SLOTS-1:0]  r_frame;
    logic                r_underrun;

    tx_state_t           w_state_next;
    logic [DIV_W-1:0]    w_div_next;
    logic                w_bclk_next;
    logic                w_lrclk_next;
    logic                w_sdata_next;
    logic [SLOT_W-1:0]   w_slot_next;
    logic [N_SLOTS-1:0]  w_frame_next;
    logic                w_underrun_next;

    // ---------------- FIFO ----------------
    logic [SAMPLE_W-1:0] w_head;
    logic                w_full;
    logic                w_empty;
    logic [LVL_W-1:0]    w_level;
    logic                w_pop;

    audio_sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk         (clk),
        .i_rst_n     (rst),
        .i_push      (sample_valid),
        .i_push_data (sample_in),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level)
    );

    // ---------------- event decode ----------------
    logic                w_div_tc;
    logic                w_fall;
    logic                w_slot_last;
    logic                w_start;
    logic                w_boundary;
    logic                w_stop;
    logic                w_reload;
    logic                w_underrun_set;
    logic [SLOT_W-1:0]   w_slot_inc;
    logic [SLOT_W-1:0]   w_bit_idx;
    logic [SAMPLE_W-1:0] w_fill;

    assign w_div_tc    = (r_div == DIV_W'(BCLK_DIV - 1));
    assign w_fall      = (r_state == RUN) && w_div_tc && r_bclk;
    assign w_slot_last = (r_slot == SLOT_W'(N_SLOTS - 1));
    assign w_slot_inc  = w_slot_last ? '0 : r_slot + SLOT_W'(1);

    // Slot s (s >= 1) carries frame bit N_SLOTS-s: the one-bit I2S delay.
    assign w_bit_idx   = SLOT_W'(N_SLOTS - int'(w_slot_inc));

    // Entry from IDLE needs at least one queued sample, so it never underruns.
    assign w_start        = (r_state == IDLE) && tx_en && !w_empty;
    assign w_boundary     = w_fall && w_slot_last;
    assign w_stop         = w_boundary && !tx_en;
    assign w_reload       = w_start || (w_boundary && tx_en);
    assign w_pop          = w_reload && !w_empty;
    assign w_underrun_set = w_reload && w_empty;

`ifdef AUDIO_I2S_TX_HOLD_LAST_EN
    logic [SAMPLE_W-1:0] r_last_sample;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_sample <= '0;
        end else if (w_pop) begin
            r_last_sample <= w_head;
        end
    end

    assign w_fill = r_last_sample;
`else
    assign w_fill = '0;
`endif

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_bclk_next  = r_bclk;
        w_lrclk_next = r_lrclk;
        w_sdata_next = r_sdata;
        w_slot_next  = r_slot;

        case (r_state)
            IDLE: begin
                // Line is parked low; entry loads the frame but does not emit
                // a bit until the first bclk falling transition.
                w_div_next   = '0;
                w_bclk_next  = 1'b0;
                w_lrclk_next = 1'b0;
                w_sdata_next = 1'b0;
                w_slot_next  = '0;
                if (w_start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_div_tc) begin
                    w_div_next  = '0;
                    w_bclk_next = ~r_bclk;
                end else begin
                    w_div_next  = r_div + DIV_W'(1);
                end
                if (w_fall) begin
                    w_slot_next  = w_slot_inc;
                    w_lrclk_next = (w_slot_inc >= SLOT_W'(SAMPLE_W));
                    // At the wrap r_frame still holds the outgoing frame, so
                    // bit 0 here is the previous right word's LSB.
                    w_sdata_next = w_slot_last ? r_frame[0] : r_frame[w_bit_idx];
                    if (w_stop) begin
                        w_state_next = IDLE;
                        w_lrclk_next = 1'b0;
                        w_sdata_next = 1'b0;
                        w_slot_next  = '0;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_frame_next = r_frame;
        if (w_reload) begin
            w_frame_next = w_pop ? {w_head, w_head} : {w_fill, w_fill};
        end
    end

    // Set has priority over a simultaneous clear.
    assign w_underrun_next = w_underrun_set | (r_underrun & ~underrun_clr);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
            r_slot     <= '0;
            r_frame    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_div      <= w_div_next;
            r_bclk     <= w_bclk_next;
            r_lrclk    <= w_lrclk_next;
            r_sdata    <= w_sdata_next;
            r_slot     <= w_slot_next;
            r_frame    <= w_frame_next;
            r_underrun <= w_underrun_next;
        end
    end

    // ---------------- outputs ----------------
    assign bclk         = r_bclk;
    assign lrclk        = r_lrclk;
    assign sdata        = r_sdata;
    assign underrun     = r_underrun;
    assign fifo_level   = w_level;
    assign sample_ready = ~w_full;

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Output stage directly downstream of the pitch-shift block.
- Accepts 16-bit processed samples on a valid/ready handshake and buffers them in a small FIFO.
- Serializes each sample as a mono-duplicated stereo frame onto a standard I2S link to the board DAC.
- Generates bclk and lrclk from the system clock and flags FIFO underrun.

Parameters:
- SAMPLE_W, 16, sample width in bits; the frame is 2*SAMPLE_W slots.
- FIFO_DEPTH, 8, sample FIFO entries; must be a power of two, 2 or more.
- BCLK_DIV, 4, clk cycles per bclk half-period; must be 1 or more.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- tx_en  input  1  enables serialization; FIFO still accepts writes when low.
- sample_in  input  SAMPLE_W  signed sample from the pitch stage.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  FIFO can accept; high when FIFO is not full.
- underrun_clr  input  1  clears the sticky underrun flag.
- bclk  output  1  I2S bit clock.
- lrclk  output  1  I2S word select; 0 = left, 1 = right.
- sdata  output  1  I2S serial data, MSB first.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun  output  1  sticky flag: a frame started with the FIFO empty.

Behaviour:
- Reset, while rst=0 and asynchronously:
  - bclk=0, lrclk=0, sdata=0, underrun=0, fifo_level=0, sample_ready=1.
  - FIFO emptied, divider=0, slot=0, frame register=0, state IDLE.
  - Reset asserted mid-frame aborts the frame immediately; no partial bits are emitted after release.
- Write handshake:
  - A push occurs when sample_valid && sample_ready at the clk edge.
  - fifo_level updates on the following cycle.
  - Push while full cannot occur, because ready=0.
- FIFO:
  - Synchronous, first-word fall-through not required.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Divider: counts 0..BCLK_DIV-1 in RUN. At terminal count, bclk toggles and the divider returns to 0.
- Slot counter: 0..31 (for SAMPLE_W=16); advances on each bclk falling transition; wraps 31->0.
- Frame boundary event: the bclk falling transition where slot goes 31->0, or the IDLE->RUN entry.
  - Pop the FIFO head into frame register F = {S,S}.
  - If the FIFO is empty, load F=0 and set underrun=1.
- Outputs updated on every bclk falling transition, one-bit I2S delay:
  - lrclk = slot[4] (left for slots 0-15, right for slots 16-31).
  - sdata = F_prev[0] at slot 0, otherwise F[32-slot].
  - F_prev is the frame held before the boundary reload.
- States:
  - IDLE: bclk=0, lrclk=0, sdata=0, divider held. Go to RUN when tx_en=1 and fifo_level>=1, performing the boundary load at slot=0.
  - RUN: free-running serialization. When tx_en=0 is sampled at a frame boundary, go to IDLE without popping. Deasserting tx_en mid-frame always completes the current frame.
- underrun:
  - Sticky until underrun_clr=1.
  - If clear and set happen in the same cycle, set wins.
  - An underrun does not stop RUN; zeros are streamed.
- Arithmetic: sample bits pass through unmodified. No saturation and no sign handling beyond MSB-first order.

Optional Feature:
- Macro: AUDIO_I2S_TX_HOLD_LAST_EN.
- Defined: an underrun frame reloads the last successfully popped sample instead of 0, to avoid clicks. underrun is still set. After reset, the "last sample" is 0.
- Undefined: an underrun frame transmits zeros.

Decomposition:
- Shared package audio_pkg holds:
  - SAMPLE_W, I2S_SLOTS=2*SAMPLE_W.
  - the tx state typedef (IDLE, RUN).
  - a $clog2-based level width constant.
- One sub-module, audio_sample_fifo (parameterised width/depth, push/pop/full/empty/level). The top holds the divider, slot counter, FSM and shifter.

Test Plan (BCLK_DIV=2, FIFO_DEPTH=8):
- Reset: drive rst=0 mid-frame with 3 samples queued -> all outputs return to reset values that cycle; after release, fifo_level=0 and bclk stays 0.
- Single frame: push 16'hA5C3, tx_en=1 ->
  - bclk period is 4 clk.
  - lrclk low for 16 bclks, then high for 16.
  - sdata in slots 1-15 = A5C3[15:1]; slot 16 = A5C3[0]; slots 17-31 = A5C3[15:1].
  - The next frame's slot 0 = A5C3[0].
- Backpressure: push 9 samples back-to-back with tx_en=0 -> sample_ready drops after the 8th; fifo_level=8; the 9th is held until a pop frees space.
- Underrun: 1 sample queued, tx_en=1 -> the second frame transmits all zeros, underrun=1; underrun_clr pulse -> 0. With the macro defined, the second frame repeats the sample.
- Stop: tx_en=0 at slot 10 -> the frame completes through slot 31, then IDLE with bclk=0 and no further pop.
- Simultaneous push/pop at a frame boundary with level=4 -> level stays 4 and FIFO order is preserved.
